oscope_axil_regfile: RTL
========================

# oscope_axil_regfile

Parametrised AXI4-Lite slave register file for the oscilloscope IP. It replaces the fixed four-register slave with three groups of registers:
- a configurable bank of read/write control registers with byte strobes and per-register write pulses;
- a bank of read-only status registers with per-register read pulses, used to pop sample FIFOs;
- SLVERR signalling for unmapped accesses and writes to read-only registers.

It sits between the AXI interconnect and the acquisition/trigger logic.

## Interface
- C_S_AXI_DATA_WIDTH, 32: data width; must be 32 or 64.
- C_S_AXI_ADDR_WIDTH, 6: address width; must be ≥ clog2(C_NUM_RW+C_NUM_RO)+clog2(C_S_AXI_DATA_WIDTH/8).
- C_NUM_RW, 8: number of read/write control registers; minimum 1.
- C_NUM_RO, 4: number of read-only status registers; minimum 0.
- ACLK  in  1  the single clock; all logic is on its rising edge.
- ARESET  in  1  asynchronous, active-high reset.
- S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address.
- S_AXI_AWPROT  in  3  accepted and ignored.
- S_AXI_AWVALID / S_AXI_AWREADY  in / out  1 each  write-address handshake.
- S_AXI_WDATA  in  C_S_AXI_DATA_WIDTH  write data.
- S_AXI_WSTRB  in  C_S_AXI_DATA_WIDTH/8  byte-lane enables.
- S_AXI_WVALID / S_AXI_WREADY  in / out  1 each  write-data handshake.
- S_AXI_BRESP  out  2  write response: OKAY (00) or SLVERR (10).
- S_AXI_BVALID / S_AXI_BREADY  out / in  1 each  write-response handshake.
- S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH  read address.
- S_AXI_ARPROT  in  3  accepted and ignored.
- S_AXI_ARVALID / S_AXI_ARREADY  in / out  1 each  read-address handshake.
- S_AXI_RDATA  out  C_S_AXI_DATA_WIDTH  read data.
- S_AXI_RRESP  out  2  read response: OKAY or SLVERR.
- S_AXI_RVALID / S_AXI_RREADY  out / in  1 each  read-data handshake.
- ctrl_regs  out  C_NUM_RW*DW  flattened control registers; register k occupies bits [k*DW +: DW].
- wr_pulse  out  C_NUM_RW  one-cycle pulse on bit k when register k is committed.
- status_in  in  C_NUM_RO*DW  flattened status words, sampled at the AR handshake.
- rd_pulse  out  C_NUM_RO  one-cycle pulse on bit k when status register k is read.

## Operation
- Address decode:
  - idx = ADDR[C_S_AXI_ADDR_WIDTH-1 : clog2(DW/8)]; the low address bits are ignored.
  - idx < C_NUM_RW selects a RW register.
  - C_NUM_RW ≤ idx < C_NUM_RW+C_NUM_RO selects RO register idx−C_NUM_RW.
  - Any larger idx is unmapped.
- Write path:
  - AW and W are accepted independently, each into its own one-entry holding register, in either order.
  - AWREADY = !ARESET && !aw_held && !BVALID. WREADY = !ARESET && !w_held && !BVALID.
  - Commit happens on the first edge where both AW and W are held. Commit clears both held flags and sets BVALID.
  - RW target: each byte lane with WSTRB=1 is updated; the other lanes are kept. BRESP=OKAY. wr_pulse[idx] is driven for exactly the one cycle after the commit edge. WSTRB=0 still commits and still pulses.
  - RO or unmapped target: no register changes, no pulse, BRESP=SLVERR.
  - BVALID and BRESP hold until the edge where BVALID&&BREADY.
- Read path:
  - ARREADY = !ARESET && !RVALID.
  - On the AR handshake edge, RDATA/RRESP are loaded and RVALID is set.
  - RW target: RDATA = the register value, OKAY.
  - RO target: RDATA = status_in word sampled at that edge, OKAY. rd_pulse[k] is driven for exactly the one cycle after the AR handshake edge.
  - Unmapped target: RDATA = 0, SLVERR.
  - RDATA, RRESP and RVALID hold until RVALID&&RREADY.
- Read and write paths are independent and may be in flight together.
- Same-register hazard: a read whose AR handshake edge is at or before the commit edge returns the old value. A read whose handshake is after the commit edge returns the new value.
- Reset values, asserted asynchronously and held while ARESET=1:
  - all ctrl_regs = 0;
  - held flags cleared;
  - BVALID = RVALID = 0; BRESP = RRESP = 0; RDATA = 0;
  - wr_pulse = rd_pulse = 0;
  - all READYs = 0.
- Reset mid-transaction: held AW/W contents are discarded with no commit, pending B/R responses are dropped, and no pulse is generated.

## Timing
- Write latency: the commit edge is the edge of the later of the AW and W handshakes plus 1. BVALID is visible from the commit edge.
- Back-to-back writes: 3 cycles per write with BREADY held high (AW/W handshake, commit, B handshake), after which the READYs reassert.
- Read latency: RVALID is visible in the cycle after the AR handshake. With RREADY held high, one read completes every 2 cycles.
- The ctrl_regs value changes at the commit edge, coincident with the wr_pulse cycle.
- All outputs are registered except the READYs, which are combinational from registered state and ARESET.

## Test plan
- Reset sequence: assert ARESET for 200 ns, release, then read every RW register → each returns 0 with OKAY, and ctrl_regs = 0 throughout.
- Write/readback, default parameters:
  - Write 0x1, 0x2, … 0x8 to registers 0..7 → reads match, BRESP=OKAY.
  - Each write → exactly one wr_pulse[k] pulse.
  - AW presented 3 cycles before W → still a single commit.
- Byte strobes: write 0xAABBCCDD with WSTRB=1111 to register 2, then 0x11223344 with WSTRB=0101 → readback = 0xAA22CC44.
- Status and error responses:
  - status_in word 1 = 0xDEADBEEF, read idx C_NUM_RW+1 → RDATA=0xDEADBEEF, one rd_pulse[1] pulse.
  - Write to that address → SLVERR, no state change.
  - Read of idx 15 → RDATA=0, SLVERR.
- Backpressure:
  - BREADY held low for 10 cycles → BVALID stays high, AWREADY=WREADY=0, no second commit.
  - RREADY held low → RDATA stable, ARREADY=0.
- Reset mid-write and alternate configuration:
  - AW held, W not yet sent, assert ARESET → after release no commit and no BVALID.
  - Repeat all scenarios with C_S_AXI_DATA_WIDTH=64, C_NUM_RW=3, C_NUM_RO=0.

Source files
------------

// File: rtl/oscope_axil_regfile.sv
// AXI4-Lite register file: RW control bank (byte strobes, write pulses), RO status bank (read pulses), SLVERR on bad access.
// Latency: write commits one edge after both AW and W are held (B visible then); RDATA/RVALID visible the cycle after AR.
// Backpressure: one AW, one W and one B/R in flight; AWREADY/WREADY drop while held or B pending, ARREADY drops while R pending.
// Ports: ACLK/ARESET; AXI4-Lite slave S_AXI_* (PROT ignored); ctrl_regs/wr_pulse towards acquisition/trigger logic;
//        status_in/rd_pulse from status sources. When C_NUM_RO = 0 these two are padded to one word / one bit and unused.
module oscope_axil_regfile #(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 6,
   parameter int C_NUM_RW           = 8,
   parameter int C_NUM_RO           = 4
) (
   input  logic                                   ACLK,
   input  logic                                   ARESET,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_AWADDR,
   input  logic [2:0]                             S_AXI_AWPROT,
   input  logic                                   S_AXI_AWVALID,
   output logic                                   S_AXI_AWREADY,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_WDATA,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
   input  logic                                   S_AXI_WVALID,
   output logic                                   S_AXI_WREADY,
   output logic [1:0]                             S_AXI_BRESP,
   output logic                                   S_AXI_BVALID,
   input  logic                                   S_AXI_BREADY,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_ARADDR,
   input  logic [2:0]                             S_AXI_ARPROT,
   input  logic                                   S_AXI_ARVALID,
   output logic                                   S_AXI_ARREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_RDATA,
   output logic [1:0]                             S_AXI_RRESP,
   output logic                                   S_AXI_RVALID,
   input  logic                                   S_AXI_RREADY,
   output logic [C_NUM_RW*C_S_AXI_DATA_WIDTH-1:0] ctrl_regs,
   output logic [C_NUM_RW-1:0]                    wr_pulse,
   input  logic [((C_NUM_RO > 0) ? C_NUM_RO : 1)*C_S_AXI_DATA_WIDTH-1:0] status_in,
   output logic [((C_NUM_RO > 0) ? C_NUM_RO : 1)-1:0]                    rd_pulse
);

   localparam int DW   = C_S_AXI_DATA_WIDTH;
   localparam int SB   = DW / 8;
   localparam int LSB  = $clog2(SB);
   localparam int IW   = C_S_AXI_ADDR_WIDTH - LSB;
   localparam int NRO1 = (C_NUM_RO > 0) ? C_NUM_RO : 1;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   // write-side holding registers
   logic          aw_held;
   logic          w_held;
   logic [IW-1:0] aw_idx;
   logic [DW-1:0] w_data;
   logic [SB-1:0] w_strb;

   logic aw_hs, w_hs, ar_hs, commit, aw_is_rw;

   // read-side decode
   logic [IW-1:0] ar_idx;
   logic [DW-1:0] rd_word;
   logic          rd_err;
   logic [NRO1-1:0] rd_onehot;

   // PROT and the byte-offset address bits carry no meaning here.
   logic unused;
   assign unused = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                     S_AXI_AWADDR[LSB-1:0], S_AXI_ARADDR[LSB-1:0], status_in};

   assign S_AXI_AWREADY = !ARESET && !aw_held && !S_AXI_BVALID;
   assign S_AXI_WREADY  = !ARESET && !w_held  && !S_AXI_BVALID;
   assign S_AXI_ARREADY = !ARESET && !S_AXI_RVALID;

   assign aw_hs    = S_AXI_AWVALID && S_AXI_AWREADY;
   assign w_hs     = S_AXI_WVALID  && S_AXI_WREADY;
   assign ar_hs    = S_AXI_ARVALID && S_AXI_ARREADY;
   assign commit   = aw_held && w_held;
   assign aw_is_rw = 32'(aw_idx) < C_NUM_RW;
   assign ar_idx   = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:LSB];

   // Write path. BVALID blocks new AW/W, so a commit can never coincide
   // with a handshake or with a pending B response.
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         aw_held      <= 1'b0;
         w_held       <= 1'b0;
         aw_idx       <= '0;
         w_data       <= '0;
         w_strb       <= '0;
         S_AXI_BVALID <= 1'b0;
         S_AXI_BRESP  <= RESP_OKAY;
         wr_pulse     <= '0;
         ctrl_regs    <= '0;
      end else begin
         wr_pulse <= '0;
         if (aw_hs) begin
            aw_held <= 1'b1;
            aw_idx  <= S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:LSB];
         end
         if (w_hs) begin
            w_held <= 1'b1;
            w_data <= S_AXI_WDATA;
            w_strb <= S_AXI_WSTRB;
         end
         if (commit) begin
            aw_held      <= 1'b0;
            w_held       <= 1'b0;
            S_AXI_BVALID <= 1'b1;
            S_AXI_BRESP  <= aw_is_rw ? RESP_OKAY : RESP_SLVERR;
            for (int k = 0; k < C_NUM_RW; k++) begin
               if (32'(aw_idx) == k) begin
                  // an all-zero strobe still counts as a commit and pulses
                  wr_pulse[k] <= 1'b1;
                  for (int b = 0; b < SB; b++) begin
                     if (w_strb[b]) ctrl_regs[k*DW + b*8 +: 8] <= w_data[b*8 +: 8];
                  end
               end
            end
         end else if (S_AXI_BVALID && S_AXI_BREADY) begin
            S_AXI_BVALID <= 1'b0;
         end
      end
   end

   // Read mux: RW bank, then RO bank, anything else is an error returning 0.
   always_comb begin
      rd_word   = '0;
      rd_err    = 1'b1;
      rd_onehot = '0;
      for (int k = 0; k < C_NUM_RW; k++) begin
         if (32'(ar_idx) == k) begin
            rd_word = ctrl_regs[k*DW +: DW];
            rd_err  = 1'b0;
         end
      end
      for (int k = 0; k < C_NUM_RO; k++) begin
         if (32'(ar_idx) == C_NUM_RW + k) begin
            rd_word      = status_in[k*DW +: DW];
            rd_err       = 1'b0;
            rd_onehot[k] = 1'b1;
         end
      end
   end

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         S_AXI_RVALID <= 1'b0;
         S_AXI_RDATA  <= '0;
         S_AXI_RRESP  <= RESP_OKAY;
         rd_pulse     <= '0;
      end else if (ar_hs) begin
         S_AXI_RVALID <= 1'b1;
         S_AXI_RDATA  <= rd_word;
         S_AXI_RRESP  <= rd_err ? RESP_SLVERR : RESP_OKAY;
         rd_pulse     <= rd_onehot;
      end else begin
         rd_pulse <= '0;
         if (S_AXI_RVALID && S_AXI_RREADY) S_AXI_RVALID <= 1'b0;
      end
   end

endmodule
